alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Registered issue and retire stage placed directly around the combinational 32-bit ALU (ports A, B, ALU_Sel, ALU_Out, Zero).
- Upstream: accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Middle: one command at a time is held in an operand register that drives the ALU inputs.
- Downstream: ALU_Out and Zero are captured into a result register with its own valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_sel  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor; 110/111 reserved.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_sel  output  3  to ALU ALU_Sel.
- alu_out  input  WIDTH  from ALU ALU_Out.
- alu_zero  input  1  from ALU Zero.
- res_valid  output  1  result present.
- res_ready  input  1  consumer takes result.
- res_data  output  WIDTH  captured ALU_Out.
- res_zero  output  1  captured Zero.
- res_sel  output  3  opcode that produced res_data.
- res_err  output  1  opcode was reserved (110/111).

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, operand stage empty, result stage empty.
  - All outputs go to 0, except cmd_ready, which is 1 once reset is released.
  - Reset mid-operation discards every buffered command and result; no partial result is ever presented.
- Command accept:
  - A command is accepted on a rising edge with cmd_valid && cmd_ready, and is written to the FIFO tail.
  - cmd_ready = !fifo_full. It is registered-state based only and never depends on res_ready.
  - cmd_a/cmd_b/cmd_sel are ignored when cmd_valid is 0.
- FIFO:
  - Circular buffer with log2(DEPTH)+1-bit read/write pointers; pointers wrap modulo DEPTH.
  - Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - Push and pop in the same cycle are allowed whenever not full; the count is unchanged.
- Operand stage (op_valid):
  - Loads the FIFO head when the FIFO is non-empty and (op_valid == 0 or the operand stage advances this cycle).
  - Advances when op_valid && (res_valid == 0 || res_ready).
  - While op_valid, alu_a/alu_b/alu_sel present the held command. When !op_valid they are driven to 0.
- Result stage:
  - Captures alu_out, alu_zero, the held sel, and err = (sel >= 3'b110) on the advance edge; res_valid is then set.
  - res_valid clears on res_valid && res_ready when no new result is advancing.
  - Outputs are stable while res_valid && !res_ready.
- Latency and throughput:
  - Command accepted at edge N, with empty pipeline: operand loaded at edge N+1, result visible after edge N+2.
  - Throughput is one result per cycle with res_ready held high.
- Backpressure: with res_ready low, the result, operand and FIFO stages fill in turn. At most DEPTH+2 commands are outstanding, after which cmd_ready = 0.
- Ordering: results appear strictly in command order. No command is dropped or duplicated.
- Reserved opcodes:
  - Issued to the ALU unchanged.
  - res_data/res_zero are whatever the ALU returns (0 and 1 for the current ALU), and res_err = 1.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined, two extra outputs are added, each cleared by reset:
  - stat_done (32): increments on each res_valid && res_ready.
  - stat_zero (32): increments on each handoff with res_zero = 1.
  - Both counters wrap from 0xFFFFFFFF to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Add: A=0x0000000A, B=0x00000005, sel=000, res_ready=1 -> two edges after accept, res_data=0x0000000F, res_zero=0, res_err=0.
- Stream: sub 0xA-0x5, and 0x0F&0xF0, or, xor, nor issued back-to-back -> in order 0x5, 0x0 (zero=1), 0xFF, 0xFF, 0xFFFFFF00; one per cycle.
- Backpressure: res_ready=0, push 7 commands with DEPTH=4 -> cmd_ready drops after the 6th accept; release res_ready -> all 6 results in order, 7th accepted once space frees.
- Reserved: sel=111, A=1, B=2 -> res_err=1, res_sel=111, res_zero matches the ALU Zero output.
- Reset mid-operation: 3 commands in flight, pulse rst_n low between edges -> res_valid=0 immediately, no stale result after release, next command yields a correct result.
- Stats (ALU_ISSUE_STATS_EN): 6-op stream above -> stat_done=6, stat_zero=1.

Source files
------------

// File: rtl/alu_issue_if.sv
// Handshake and ALU-facing signal bundle for alu_issue_stage.
// slave: the issue stage itself; master: the command source, ALU and result consumer.
interface alu_issue_if #(
  parameter int WIDTH = 32
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_sel;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic [2:0]       res_sel;
  logic             res_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_zero, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel,
    output res_valid, res_data, res_zero, res_sel, res_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_zero, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel,
    input  res_valid, res_data, res_zero, res_sel, res_err
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Command FIFO -> operand register -> combinational ALU -> result register.
// Define ALU_ISSUE_STATS_EN to add the stat_done/stat_zero handoff counters.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0] stat_done,
  output logic [31:0] stat_zero
`endif
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
    $error("alu_issue_stage: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
  } cmd_t;

  cmd_t             r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  cmd_t             r_op;
  logic             r_op_valid;

  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_zero;
  logic [2:0]       r_res_sel;
  logic             r_res_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_adv;
  logic             w_handoff;
  cmd_t             w_cmd;

  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_push    = bus.cmd_valid && !w_full;
  assign w_adv     = r_op_valid && (!r_res_valid || bus.res_ready);
  assign w_pop     = !w_empty && (!r_op_valid || w_adv);
  assign w_handoff = r_res_valid && bus.res_ready;
  assign w_cmd     = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};

  // Storage is not reset: clearing the pointers is enough to discard entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_op_valid <= 1'b0;
    end else if (w_pop) begin
      r_op       <= r_mem[r_rptr[AW-1:0]];
      r_op_valid <= 1'b1;
    end else if (w_adv) begin
      r_op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_zero  <= 1'b0;
      r_res_sel   <= '0;
      r_res_err   <= 1'b0;
    end else if (w_adv) begin
      r_res_valid <= 1'b1;
      r_res_data  <= bus.alu_out;
      r_res_zero  <= bus.alu_zero;
      r_res_sel   <= r_op.sel;
      r_res_err   <= (r_op.sel >= 3'b110);
    end else if (w_handoff) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.alu_a     = r_op_valid ? r_op.a   : '0;
  assign bus.alu_b     = r_op_valid ? r_op.b   : '0;
  assign bus.alu_sel   = r_op_valid ? r_op.sel : '0;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_zero  = r_res_zero;
  assign bus.res_sel   = r_res_sel;
  assign bus.res_err   = r_res_err;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] r_stat_done;
  logic [31:0] r_stat_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_done <= '0;
      r_stat_zero <= '0;
    end else if (w_handoff) begin
      r_stat_done <= r_stat_done + 32'd1;
      if (r_res_zero) begin
        r_stat_zero <= r_stat_zero + 32'd1;
      end
    end
  end

  assign stat_done = r_stat_done;
  assign stat_zero = r_stat_zero;
`else
  // No handoff counters in this build.
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with a behavioural ALU.
// Stat counter checks are compiled in when ALU_ISSUE_STATS_EN is defined.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_issue_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_done;
  logic [31:0] stat_zero;
`endif

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_done (stat_done),
    .stat_zero (stat_zero)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: reserved opcodes return 0.
  always_comb begin
    case (bus.alu_sel)
      3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      3'b101:  bus.alu_out = ~(bus.alu_a | bus.alu_b);
      default: bus.alu_out = '0;
    endcase
  end
  assign bus.alu_zero = (bus.alu_out == '0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
  endtask

  logic [31:0] s_a   [5] = '{32'h0000000A, 32'h0000000F, 32'h0000000F, 32'h0000000F, 32'h0000000F};
  logic [31:0] s_b   [5] = '{32'h00000005, 32'h000000F0, 32'h000000F0, 32'h000000F0, 32'h000000F0};
  logic [2:0]  s_sel [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
  logic [31:0] s_exp [5] = '{32'h00000005, 32'h00000000, 32'h000000FF, 32'h000000FF, 32'hFFFFFF00};
  logic        s_zero[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int k;
    int first;
    int last;
    int seen;
    logic drop;

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.res_ready = 1'b0;

    #12;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data",  bus.res_data, 0);
    check("rst_res_err",   bus.res_err, 0);
    check("rst_alu_a",     bus.alu_a, 0);
    check("rst_alu_sel",   bus.alu_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_res_valid2", bus.res_valid, 0);

    // Single add with exact latency.
    bus.res_ready = 1'b1;
    drive(32'h0000000A, 32'h00000005, 3'b000);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("add_op_empty", bus.alu_a, 0);
    @(negedge clk);
    check("add_alu_a",   bus.alu_a, 32'h0000000A);
    check("add_alu_b",   bus.alu_b, 32'h00000005);
    check("add_alu_sel", bus.alu_sel, 0);
    check("add_no_res",  bus.res_valid, 0);
    @(negedge clk);
    check("add_valid", bus.res_valid, 1);
    check("add_data",  bus.res_data, 32'h0000000F);
    check("add_zero",  bus.res_zero, 0);
    check("add_err",   bus.res_err, 0);
    check("add_sel",   bus.res_sel, 0);
    @(negedge clk);
    check("add_cleared", bus.res_valid, 0);

    // Back-to-back stream with res_ready held high.
    k = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
      if (bus.res_valid) begin
        check("stream_data", bus.res_data, s_exp[k]);
        check("stream_zero", bus.res_zero, s_zero[k]);
        check("stream_sel",  bus.res_sel, s_sel[k]);
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
      if (cyc < 5) begin
        check("stream_ready", bus.cmd_ready, 1);
        drive(s_a[cyc], s_b[cyc], s_sel[cyc]);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("stream_count", k, 5);
    check("stream_rate", last - first, 4);
`ifdef ALU_ISSUE_STATS_EN
    check("stat_done", stat_done, 6);
    check("stat_zero", stat_zero, 1);
`endif

    // Backpressure: six commands fill result, operand and FIFO.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("bp_ready", bus.cmd_ready, 1);
      drive(32'd100 + i, i, 3'b000);
      @(negedge clk);
    end
    check("bp_full", bus.cmd_ready, 0);
    drive(32'd106, 32'd6, 3'b000);
    check("bp_head_valid", bus.res_valid, 1);
    check("bp_head_data", bus.res_data, 32'd100);
    repeat (3) @(negedge clk);
    check("bp_still_full", bus.cmd_ready, 0);
    check("bp_hold", bus.res_data, 32'd100);
    bus.res_ready = 1'b1;
    k = 0; drop = 1'b0;
    for (int cyc = 0; cyc < 40 && k < 7; cyc++) begin
      if (bus.res_valid) begin
        check("bp_data", bus.res_data, 32'd100 + 2 * k);
        k++;
      end
      if (drop) bus.cmd_valid = 1'b0;
      else if (bus.cmd_valid && bus.cmd_ready) drop = 1'b1;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("bp_count", k, 7);
    check("bp_7th_accepted", drop, 1);

    // Reserved opcode passes through and flags err.
    drive(32'd1, 32'd2, 3'b111);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rsv_alu_sel", bus.alu_sel, 3'b111);
    check("rsv_alu_b",   bus.alu_b, 32'd2);
    @(negedge clk);
    check("rsv_valid", bus.res_valid, 1);
    check("rsv_err",   bus.res_err, 1);
    check("rsv_sel",   bus.res_sel, 3'b111);
    check("rsv_zero",  bus.res_zero, 1);
    check("rsv_data",  bus.res_data, 0);
    @(negedge clk);

    // Reset with three commands in flight.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h50 + i, 32'h1, 3'b000);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("mid_pre_valid", bus.res_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_data",  bus.res_data, 0);
    check("mid_rst_alu_a", bus.alu_a, 0);
    #1 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    check("mid_no_stale", seen, 0);
    check("mid_cmd_ready", bus.cmd_ready, 1);
`ifdef ALU_ISSUE_STATS_EN
    check("mid_stat_done", stat_done, 0);
`endif
    drive(32'h00001234, 32'h00001111, 3'b000);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_post_valid", bus.res_valid, 1);
    check("mid_post_data",  bus.res_data, 32'h00002345);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
